radix2_divider: RTL and testbench

RADIX2_DIVIDER -- requirements
Module: radix2_divider

---
 rtl/radix2_divider_pkg.sv | 14 +
 rtl/radix2_divider.sv | 76 +++++++
 tb/tb_radix2_divider.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/radix2_divider_pkg.sv
// radix2_divider_pkg: shared state encodings and handshake constants for the radix-2 divider
package radix2_divider_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIVZERO = 2'b01,
    BUSY    = 2'b10,
    DONE    = 2'b11
  } state_t;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0;
endpackage

// File: rtl/radix2_divider.sv
// radix2_divider: multi-cycle restoring divider, signed/unsigned, one quotient bit per clock
module radix2_divider
  import radix2_divider_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  localparam int CW = $clog2(DATA_W) + 1;
  state_t state, state_nxt;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] q, d, r, a_mag, b_mag;
  logic [DATA_W:0] r_shift, trial;
  logic neg_q, neg_r, a_neg, b_neg, accept, last;
  assign a_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign b_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign a_mag = a_neg ? DATA_W'(0) - opdata1_i : opdata1_i;
  assign b_mag = b_neg ? DATA_W'(0) - opdata2_i : opdata2_i;
  assign accept = (state == IDLE) && (start_i == DIV_START) && !annul_i;
  assign last = count == CW'(DATA_W - 1);
  // trial subtraction on the widened partial remainder; its sign bit decides restore
  assign r_shift = {r, q[DATA_W-1]};
  assign trial = r_shift - {1'b0, d};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (opdata2_i == '0 ? DIVZERO : BUSY) : IDLE;
      DIVZERO: state_nxt = annul_i ? IDLE : DONE;
      BUSY:    state_nxt = annul_i ? IDLE : (last ? DONE : BUSY);
      DONE:    state_nxt = start_i == DIV_START ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      q     <= '0;
      d     <= '0;
      r     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      count <= '0;
      q     <= a_mag;
      d     <= b_mag;
      r     <= '0;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end else if (state == DIVZERO) begin
      q     <= '0;
      r     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == BUSY) begin
      count <= count + 1'b1;
      r     <= trial[DATA_W] ? r_shift[DATA_W-1:0] : trial[DATA_W-1:0];
      q     <= {q[DATA_W-2:0], ~trial[DATA_W]};
    end
  end
  // signs are reapplied only at the output so the iteration works on magnitudes throughout
  assign ready_o = state == DONE ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign result_o = state == DONE ? {neg_r ? DATA_W'(0) - r : r, neg_q ? DATA_W'(0) - q : q}
                                  : '0;
endmodule

// File: tb/tb_radix2_divider.sv
// tb_radix2_divider: randomized and directed checks of radix2_divider against an arithmetic model
module tb_radix2_divider;
  logic        clk = 0;
  logic        resetn = 0;
  logic        signed_div_i = 0;
  logic [31:0] opdata1_i = 0;
  logic [31:0] opdata2_i = 0;
  logic        start_i = 0;
  logic        annul_i = 0;
  logic [63:0] result_o;
  logic        ready_o;
  int passed = 0;
  int total = 0;

  radix2_divider #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .start_i(start_i),
    .annul_i(annul_i), .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, qq, rr;
    if (b == 0) return 64'h0;
    x = sgn ? longint'(signed'(a)) : longint'(a);
    y = sgn ? longint'(signed'(b)) : longint'(b);
    qq = x / y;
    rr = x % y;
    return {rr[31:0], qq[31:0]};
  endfunction

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold,
                        output int lat, output logic [63:0] res, output bit held_ok, output bit idle_ok);
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1;
    @(posedge clk); #1;
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (ready_o) begin lat = i; break; end
    end
    res = result_o;
    held_ok = 1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!ready_o || result_o !== res) held_ok = 0;
    end
    @(negedge clk); start_i = 0;
    @(posedge clk); #1;
    idle_ok = !ready_o && result_o == 64'h0;
  endtask

  task automatic test_reset();
    #23;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) $display("FAIL reset: ready=%b result=%h want 0/0", ready_o, result_o);
    else passed++;
    @(negedge clk); resetn = 1;
  endtask

  task automatic test_unsigned_basic();
    int lat; logic [63:0] res; bit h, idl;
    run_op(0, 32'd100, 32'd7, 3, lat, res, h, idl);
    total++;
    if (lat !== 32) $display("FAIL u100_7 latency: got %0d want 32", lat); else passed++;
    total++;
    if (res !== {32'd2, 32'd14}) $display("FAIL u100_7 result: got %h want %h", res, {32'd2, 32'd14}); else passed++;
    total++;
    if (!h) $display("FAIL u100_7 hold: result not held while start high, got 0 want 1"); else passed++;
    total++;
    if (!idl) $display("FAIL u100_7 drop: ready/result not cleared after start drop, got 0 want 1"); else passed++;
  endtask

  task automatic test_signed_cases();
    int lat; logic [63:0] res; bit h, idl;
    run_op(1, -32'sd7, 32'd2, 0, lat, res, h, idl);
    total++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) $display("FAIL s-7_2: got %h want ffffffff_fffffffd", res); else passed++;
    run_op(1, 32'd7, -32'sd2, 0, lat, res, h, idl);
    total++;
    if (res !== {32'h1, 32'hFFFFFFFD}) $display("FAIL s7_-2: got %h want 00000001_fffffffd", res); else passed++;
    run_op(1, 32'h80000000, 32'hFFFFFFFF, 0, lat, res, h, idl);
    total++;
    if (res !== {32'h0, 32'h80000000}) $display("FAIL smin_-1: got %h want 00000000_80000000", res); else passed++;
    run_op(0, 32'hFFFFFFF9, 32'd2, 0, lat, res, h, idl);
    total++;
    if (res !== model(0, 32'hFFFFFFF9, 32'd2)) $display("FAIL u_big: got %h want %h", res, model(0, 32'hFFFFFFF9, 32'd2)); else passed++;
  endtask

  task automatic test_divzero();
    int lat; logic [63:0] res; bit h, idl;
    for (int k = 0; k < 3; k++) begin
      run_op(k[0], k == 0 ? 32'h0 : $urandom, 32'h0, 1, lat, res, h, idl);
      total++;
      if (lat !== 1 || res !== 64'h0) $display("FAIL divzero%0d: lat=%0d res=%h want 1/0", k, lat, res); else passed++;
    end
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; bit h, idl; bit seen = 0;
    @(negedge clk);
    signed_div_i = 0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); annul_i = 1; start_i = 0;
    @(negedge clk); annul_i = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) seen = 1; end
    total++;
    if (seen) $display("FAIL annul: ready seen after annul, got 1 want 0"); else passed++;
    run_op(0, 32'd9, 32'd3, 0, lat, res, h, idl);
    total++;
    if (lat !== 32 || res !== {32'd0, 32'd3}) $display("FAIL after_annul: lat=%0d res=%h want 32/%h", lat, res, {32'd0, 32'd3}); else passed++;
  endtask

  task automatic test_reset_busy();
    int lat; logic [63:0] res; bit h, idl;
    @(negedge clk);
    signed_div_i = 0; opdata1_i = 32'd77777; opdata2_i = 32'd5; start_i = 1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 resetn = 0; start_i = 0;
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) $display("FAIL reset_busy: ready=%b result=%h want 0/0", ready_o, result_o); else passed++;
    @(negedge clk); resetn = 1;
    run_op(0, 32'hFFFFFFFF, 32'd1, 0, lat, res, h, idl);
    total++;
    if (lat !== 32 || res !== {32'h0, 32'hFFFFFFFF}) $display("FAIL post_reset: lat=%0d res=%h want 32/00000000ffffffff", lat, res); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [63:0] r1, r2; bit h, idl;
    run_op(0, 32'd50, 32'd6, 0, lat1, r1, h, idl);
    run_op(1, -32'sd50, 32'd6, 0, lat2, r2, h, idl);
    total++;
    if (lat1 !== 32 || lat2 !== 32) $display("FAIL b2b latency: got %0d/%0d want 32/32", lat1, lat2); else passed++;
    total++;
    if (r2 !== model(1, -32'sd50, 32'd6)) $display("FAIL b2b result: got %h want %h", r2, model(1, -32'sd50, 32'd6)); else passed++;
  endtask

  task automatic test_random();
    int lat; logic [63:0] res, exp; bit h, idl;
    logic [31:0] a, b; bit s;
    for (int n = 0; n < 1400; n++) begin
      s = n[0];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(1, 15);
        1: b = 32'hFFFFFFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 50) == 0) b = 0;
      exp = model(s, a, b);
      run_op(s, a, b, 0, lat, res, h, idl);
      total++;
      if (res !== exp || lat !== (b == 0 ? 1 : 32))
        $display("FAIL random%0d s=%0d a=%h b=%h: res=%h lat=%0d want %h/%0d", n, s, a, b, res, lat, exp, b == 0 ? 1 : 32);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_cases();
    test_divzero();
    test_annul();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
